// File: rtl/aidc_lite_line_pack.sv
// Packs AIDC-Lite code word writes into one line and presents it on a valid/ready port.
// A failed or empty block falls back to the original uncompressed line.
module aidc_lite_line_pack #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid_i,
  input  logic [$clog2(NUM_WORDS)-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0]                wr_data_i,
  input  logic                             done_i,
  input  logic                             fail_i,
  input  logic                             raw_valid_i,
  input  logic [WORD_W*NUM_WORDS-1:0]      raw_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [WORD_W*NUM_WORDS-1:0]      out_data_o,
  output logic [$clog2(NUM_WORDS):0]       out_len_o,
  output logic                             out_comp_o,
  output logic                             busy_o,
  output logic                             ovf_o
);

  localparam int unsigned AW     = $clog2(NUM_WORDS);
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned LINE_W = WORD_W * NUM_WORDS;

  typedef enum logic {S_COLLECT, S_OUT} state_t;

  state_t              state;
  logic [WORD_W-1:0]   slots    [NUM_WORDS];
  logic [WORD_W-1:0]   slots_nx [NUM_WORDS];
  logic [NUM_WORDS-1:0] written, written_nx;
  logic [AW-1:0]       max_addr, max_nx;
  logic [LINE_W-1:0]   raw_buf;
  logic [LINE_W-1:0]   packed_nx;
  logic                done_q;
  logic                end_evt;

  assign end_evt = done_i & ~done_q;

  // Buffer contents including this cycle's write, so a write coincident
  // with the end event lands in the emitted line.
  always_comb begin
    slots_nx   = slots;
    written_nx = written;
    max_nx     = max_addr;
    if (wr_valid_i) begin
      slots_nx[wr_addr_i]   = wr_data_i;
      written_nx[wr_addr_i] = 1'b1;
      if (wr_addr_i > max_addr) max_nx = wr_addr_i;
    end
    packed_nx = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      packed_nx[LINE_W-1-k*WORD_W -: WORD_W] = slots_nx[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_COLLECT;
      slots      <= '{default: '0};
      written    <= '0;
      max_addr   <= '0;
      raw_buf    <= '0;
      done_q     <= 1'b1;
      out_data_o <= '0;
      out_len_o  <= '0;
      out_comp_o <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      done_q <= done_i;
      case (state)
        S_COLLECT: begin
          slots    <= slots_nx;
          written  <= written_nx;
          max_addr <= max_nx;
          if (raw_valid_i) raw_buf <= raw_data_i;
          if (end_evt) begin
            state <= S_OUT;
            if (!fail_i && (|written_nx)) begin
              out_data_o <= packed_nx;
              out_len_o  <= LW'(max_nx) + LW'(1);
              out_comp_o <= 1'b1;
            end else begin
              out_data_o <= raw_valid_i ? raw_data_i : raw_buf;
              out_len_o  <= LW'(NUM_WORDS);
              out_comp_o <= 1'b0;
            end
          end
        end
        S_OUT: begin
          if (wr_valid_i || raw_valid_i || end_evt) ovf_o <= 1'b1;
          if (out_ready_i) begin
            state    <= S_COLLECT;
            slots    <= '{default: '0};
            written  <= '0;
            max_addr <= '0;
          end
        end
      endcase
    end
  end

  assign out_valid_o = (state == S_OUT);
  assign busy_o      = (state == S_OUT);

endmodule

// File: tb/tb_aidc_lite_line_pack.sv
// Bench for aidc_lite_line_pack: directed scenarios plus random traffic, checked
// against a block-level reference model of the line packer.
module tb_aidc_lite_line_pack;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid_i;
  logic [2:0]   wr_addr_i;
  logic [63:0]  wr_data_i;
  logic         done_i;
  logic         fail_i;
  logic         raw_valid_i;
  logic [511:0] raw_data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [511:0] out_data_o;
  logic [3:0]   out_len_o;
  logic         out_comp_o;
  logic         busy_o;
  logic         ovf_o;

  aidc_lite_line_pack #(.WORD_W(64), .NUM_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .done_i(done_i), .fail_i(fail_i),
    .raw_valid_i(raw_valid_i), .raw_data_i(raw_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_len_o(out_len_o), .out_comp_o(out_comp_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: block contents plus the pending line, if any.
  logic [63:0]  m_words [8];
  logic [7:0]   m_wr;
  logic [511:0] m_raw;
  logic         m_pend;
  logic         m_ovf;
  logic         m_doneq;
  logic [511:0] m_data;
  logic [3:0]   m_len;
  logic         m_comp;
  logic         dlev;
  logic [511:0] a5_line;
  logic [511:0] held;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) m_words[k] = '0;
    m_wr = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_raw = '0; m_pend = 1'b0; m_ovf = 1'b0; m_doneq = 1'b1;
    m_data = '0; m_len = '0; m_comp = 1'b0;
  endtask

  task automatic build_line(input logic fl);
    int hi;
    hi = -1;
    for (int k = 0; k < 8; k++) if (m_wr[k]) hi = k;
    if (!fl && hi >= 0) begin
      m_data = '0;
      for (int k = 0; k < 8; k++)
        if (m_wr[k]) m_data[511-64*k -: 64] = m_words[k];
      m_len  = 4'(hi + 1);
      m_comp = 1'b1;
    end else begin
      m_data = m_raw;
      m_len  = 4'd8;
      m_comp = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, out_valid_o, m_pend);
    chk({tag, ".busy"}, busy_o, m_pend);
    chk({tag, ".ovf"}, ovf_o, m_ovf);
    if (m_pend) begin
      chk({tag, ".data"}, out_data_o, m_data);
      chk({tag, ".len"}, out_len_o, m_len);
      chk({tag, ".comp"}, out_comp_o, m_comp);
    end
  endtask

  // One clock cycle: entered and left at the falling edge.
  task automatic cyc(input string tag, input logic wv, input int wa, input logic [63:0] wd,
                     input logic dn, input logic fl, input logic rv, input logic [511:0] rd,
                     input logic rdy);
    logic rise;
    wr_valid_i = wv; wr_addr_i = 3'(wa); wr_data_i = wd;
    done_i = dn; fail_i = fl; raw_valid_i = rv; raw_data_i = rd; out_ready_i = rdy;
    dlev = dn;
    rise = dn && !m_doneq;
    if (!m_pend) begin
      if (wv) begin m_words[wa] = wd; m_wr[wa] = 1'b1; end
      if (rv) m_raw = rd;
      if (rise) begin build_line(fl); m_pend = 1'b1; end
    end else begin
      if (wv || rv || rise) m_ovf = 1'b1;
      if (rdy) begin m_pend = 1'b0; model_clear(); end
    end
    m_doneq = dn;
    @(posedge clk); #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic dn, input logic rdy);
    cyc(tag, 1'b0, 0, '0, dn, 1'b0, 1'b0, '0, rdy);
  endtask

  task automatic wr(input string tag, input int a, input logic [63:0] d, input logic dn,
                    input logic fl, input logic rdy);
    cyc(tag, 1'b1, a, d, dn, fl, 1'b0, '0, rdy);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1; wr_valid_i = 1'b0; raw_valid_i = 1'b0;
    #1;
    model_reset();
    chk({tag, ".valid_async"}, out_valid_o, 1'b0);
    chk({tag, ".ovf_async"}, ovf_o, 1'b0);
    chk({tag, ".busy_async"}, busy_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    done_i = 1'b1; fail_i = 1'b0; raw_valid_i = 1'b0; raw_data_i = '0; out_ready_i = 1'b0;
    dlev = 1'b1;
    for (int k = 0; k < 64; k++) a5_line[8*k +: 8] = 8'hA5;
    model_reset();
    @(posedge clk); #1;
    chk("rst.valid", out_valid_o, 1'b0);
    chk("rst.data", out_data_o, 512'd0);
    chk("rst.len", out_len_o, 4'd0);
    chk("rst.comp", out_comp_o, 1'b0);
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.ovf", ovf_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle("t0.idle_high", 1'b1, 1'b1);

    // 1: four words, end event on the last write cycle
    wr("t1.w0", 0, {16{4'h1}}, 1'b0, 1'b0, 1'b1);
    wr("t1.w1", 1, {16{4'h2}}, 1'b0, 1'b0, 1'b1);
    wr("t1.w2", 2, {16{4'h3}}, 1'b0, 1'b0, 1'b1);
    wr("t1.w3", 3, {16{4'h4}}, 1'b1, 1'b0, 1'b1);
    chk("t1.len_const", out_len_o, 4'd4);
    chk("t1.comp_const", out_comp_o, 1'b1);
    chk("t1.data_const", out_data_o, {{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 256'd0});
    idle("t1.hs", 1'b1, 1'b1);
    chk("t1.collect", out_valid_o, 1'b0);

    // 2: raw fallback on fail
    idle("t2.fall", 1'b0, 1'b1);
    cyc("t2.raw", 1'b0, 0, '0, 1'b0, 1'b0, 1'b1, a5_line, 1'b1);
    for (int a = 0; a < 8; a++)
      wr("t2.w", a, {$urandom, $urandom}, (a == 7) ? 1'b1 : 1'b0, (a == 7) ? 1'b1 : 1'b0, 1'b1);
    chk("t2.comp_const", out_comp_o, 1'b0);
    chk("t2.len_const", out_len_o, 4'd8);
    chk("t2.data_const", out_data_o, a5_line);
    idle("t2.hs", 1'b1, 1'b1);

    // 3 and 4: backpressure, with a dropped write while the line is held
    idle("t3.fall", 1'b0, 1'b0);
    wr("t3.w5", 5, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0);
    wr("t3.w1", 1, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 1'b0);
    held = out_data_o;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wr("t4.drop", 0, 64'hDEAD, 1'b1, 1'b0, 1'b0);
      else idle("t3.hold", 1'b1, 1'b0);
      chk("t3.data_stable", out_data_o, held);
      chk("t3.len_const", out_len_o, 4'd6);
    end
    chk("t4.ovf_const", ovf_o, 1'b1);
    idle("t3.hs", 1'b1, 1'b1);
    chk("t3.collect", busy_o, 1'b0);
    idle("t4.fall", 1'b0, 1'b1);
    wr("t4.next", 2, 64'h5555_AAAA_5555_AAAA, 1'b1, 1'b0, 1'b1);
    chk("t4.empty_slots", out_data_o, {128'd0, 64'h5555_AAAA_5555_AAAA, 320'd0});
    chk("t4.ovf_sticky", ovf_o, 1'b1);
    idle("t4.hs", 1'b1, 1'b1);

    // 5: reset mid-collection and during OUT
    idle("t5.fall", 1'b0, 1'b1);
    wr("t5.w0", 0, 64'h1, 1'b0, 1'b0, 1'b1);
    wr("t5.w1", 1, 64'h2, 1'b0, 1'b0, 1'b1);
    wr("t5.w2", 2, 64'h3, 1'b1, 1'b0, 1'b0);
    do_reset("t5.rst_out");
    idle("t5.after_rst", 1'b1, 1'b1);
    idle("t5.after_rst2", 1'b0, 1'b1);
    wr("t5.w0b", 0, 64'h7, 1'b0, 1'b0, 1'b1);
    wr("t5.w1b", 1, 64'h8, 1'b0, 1'b0, 1'b1);
    wr("t5.w4b", 4, 64'h9, 1'b0, 1'b0, 1'b1);
    do_reset("t5.rst_mid");
    idle("t5.hold_done0", 1'b0, 1'b1);
    wr("t5.fresh", 1, 64'hCAFE, 1'b1, 1'b0, 1'b1);
    chk("t5.fresh_line", out_data_o, {64'd0, 64'hCAFE, 384'd0});
    chk("t5.fresh_len", out_len_o, 4'd2);
    idle("t5.hs", 1'b1, 1'b1);

    // 6: end event with no writes
    idle("t6.fall", 1'b0, 1'b1);
    idle("t6.rise", 1'b1, 1'b1);
    chk("t6.comp_const", out_comp_o, 1'b0);
    chk("t6.len_const", out_len_o, 4'd8);
    idle("t6.hs", 1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [511:0] rd;
      for (int k = 0; k < 16; k++) rd[32*k +: 32] = $urandom;
      cyc("rnd", ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)), {$urandom, $urandom},
          ($urandom_range(0, 3) == 0) ? ~dlev : dlev, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), rd, ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aidc_lite_line_pack.md
# aidc_lite_line_pack

- Downstream stage of the AIDC-Lite code concatenator: collects its 64-bit word writes (`addr`/`data`/`done`/`fail`) into a 512-bit line.
- On end-of-block, emits either the compressed line or, on compression failure, the original uncompressed line.
- Presents the result on a valid/ready port toward the line-buffer/memory-write stage.

## Interface

Parameters:
- `WORD_W`, 64, width of one code word.
- `NUM_WORDS`, 8, words per line. Line width is `WORD_W*NUM_WORDS` = 512.

Ports:
- `clk`, input, 1: the only clock; all logic on posedge.
- `rst`, input, 1: asynchronous, active-high reset.
- `wr_valid_i`, input, 1: code word write strobe from the concatenator.
- `wr_addr_i`, input, 3: word index 0..7.
- `wr_data_i`, input, 64: code word.
- `done_i`, input, 1: level; falls at start of block, rises when the block is complete.
- `fail_i`, input, 1: valid with the `done_i` rise; block exceeded 512 bits.
- `raw_valid_i`, input, 1: one-cycle strobe; original line for the current block.
- `raw_data_i`, input, 512: original uncompressed line.
- `out_valid_o`, output, 1: line available.
- `out_ready_i`, input, 1: consumer accepts the line.
- `out_data_o`, output, 512: line. Word 0 is in bits [511:448]; word k is in [511-64k : 448-64k].
- `out_len_o`, output, 4: number of valid words, 1..8.
- `out_comp_o`, output, 1: 1 = compressed line, 0 = raw fallback.
- `busy_o`, output, 1: high while a line is pending output.
- `ovf_o`, output, 1: sticky; input was dropped while busy. Cleared only by reset.

## Operation

States:
- **COLLECT** (reset state)
- **OUT**

COLLECT:
- `wr_valid_i` writes `wr_data_i` into word slot `wr_addr_i`, sets that slot's written bit, and updates `max_addr` = max(`max_addr`, `wr_addr_i`).
- `raw_valid_i` loads `raw_buf`; the last strobe wins.
- The end event is a `done_i` rising edge, `done_i & ~done_q`. `done_q` resets to 1, matching the upstream reset value of `done`.
- A write in the same cycle as the end event is included in the line.
- On the end event, the line is selected and registered and the state moves to OUT:
  - **Compressed:** when `fail_i`=0 and at least one word has been written. `out_data_o` = word slots, with unwritten slots driven as zero; `out_len_o` = `max_addr`+1; `out_comp_o`=1.
  - **Raw fallback:** otherwise. `out_data_o` = `raw_buf`, `out_len_o`=8, `out_comp_o`=0.

OUT:
- `out_valid_o`=1 and `busy_o`=1.
- Output fields stay stable until `out_valid_o & out_ready_i`.
- Any `wr_valid_i`, `raw_valid_i` or `done_i` rise while in OUT is dropped and sets `ovf_o`. Word and raw buffers are not modified.
- On handshake: clear word slots, written bits and `max_addr`, then return to COLLECT.

Other rules:
- `done_q` tracks `done_i` every cycle in both states. A `done_i` rise during OUT is therefore consumed and not replayed.
- Rewriting an already-written slot overwrites it; the last write wins.
- `fail_i` is sampled only at the end event.

## Timing

- Reset values: `out_valid_o`=0, `out_data_o`=0, `out_len_o`=0, `out_comp_o`=0, `busy_o`=0, `ovf_o`=0. State = COLLECT; all buffers zero; `done_q`=1; `max_addr`=0.
- Reset is asynchronous; it takes effect mid-line or mid-OUT and discards everything.
- Latency: end event at cycle T gives `out_valid_o`=1 at T+1.
- With `out_ready_i` held high, the handshake completes at T+1 and COLLECT resumes at T+2. Writes at T+2 are accepted.
- A write at T+1 (OUT state) is dropped and sets `ovf_o`.
- No combinational path from any input to any output. `out_ready_i` affects only the next state.
- Throughput: one line per two cycles minimum. The upstream minimum line period (≥3 cycles) never overflows when `out_ready_i`=1.

## Test plan

1. Write addr 0..3 with 0x1111…, 0x2222…, 0x3333…, 0x4444…; `done_i` rises with `fail_i`=0 on the addr-3 cycle; `out_ready_i`=1.
   - Expect: one cycle later `out_valid_o`=1, `out_len_o`=4, `out_comp_o`=1, words 0..3 as written, words 4..7 zero.
2. `raw_valid_i` with pattern 0xA5…A5; write 8 words; `done_i` rises with `fail_i`=1.
   - Expect: `out_comp_o`=0, `out_len_o`=8, `out_data_o`=0xA5…A5.
3. Hold `out_ready_i`=0 for 5 cycles after the end event.
   - Expect: `out_valid_o`, data, length and `busy_o` stable for 5 cycles; transfer on the first ready cycle; COLLECT the next cycle.
4. While in OUT, issue `wr_valid_i` addr 0 with data 0xDEAD.
   - Expect: `ovf_o`=1 stays set; the pending line is unchanged; after the handshake the next line starts with empty slots.
5. Assert `rst` mid-collection after 3 writes, and again during OUT.
   - Expect: immediately `out_valid_o`=0 and `ovf_o`=0. After release, no end event fires while `done_i` is held high, and the next line is independent.
6. `done_i` rises with no preceding writes and `fail_i`=0.
   - Expect: raw fallback, `out_comp_o`=0, `out_len_o`=8.
